// File: rtl/tft_pwm_pkg.sv
// Shared types and defaults for the multi-channel backlight PWM dimmer.
package tft_pwm_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } ramp_state_e;

   localparam int DEF_CH          = 1;
   localparam int DEF_RES_W       = 4;
   localparam int DEF_PRESC_W     = 15;
   localparam int DEF_PRESC_DIV   = 20000;
   localparam int DEF_STARTUP_CNT = 12288;
   localparam int DEF_RATE_W      = 8;

   // Low bit of channel ch's slice inside a packed per-channel duty bus.
   function automatic int duty_lo(input int ch, input int res_w);
      return ch * res_w;
   endfunction

endpackage

// File: rtl/tft_pwm_channel.sv
// One PWM channel: target capture, soft-fade ramp FSM and registered compare output.
module tft_pwm_channel
   import tft_pwm_pkg::*;
#(
   parameter int RES_W  = DEF_RES_W,
   parameter int RATE_W = DEF_RATE_W
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              ready,
   input  logic              boundary,
   input  logic [RES_W-1:0]  phase,
   input  logic              load,
   input  logic [RES_W-1:0]  load_duty,
   input  logic [RATE_W-1:0] ramp_rate,
   output logic              pwm_out,
   output logic [RES_W-1:0]  cur_duty,
   output logic              ramp_busy
);

   localparam logic [RES_W-1:0] DUTY_FULL = {RES_W{1'b1}};
   localparam logic [RES_W-1:0] DUTY_ZERO = {RES_W{1'b0}};

   ramp_state_e       state_r, state_nx_s;
   logic [RES_W-1:0]  target_r, target_nx_s;
   logic [RES_W-1:0]  cur_r, cur_nx_s;
   logic [RATE_W-1:0] cnt_r, cnt_nx_s;
   logic [RATE_W:0]   cnt_inc_s;
   logic              pwm_r, pwm_nx_s;
   logic              busy_s;

   // State and output registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_r  <= ST_IDLE;
         target_r <= DUTY_ZERO;
         cur_r    <= DUTY_ZERO;
         cnt_r    <= {RATE_W{1'b0}};
         pwm_r    <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         target_r <= target_nx_s;
         cur_r    <= cur_nx_s;
         cnt_r    <= cnt_nx_s;
         pwm_r    <= pwm_nx_s;
      end
   end

   // Next-state: a load always wins over a boundary step; steps only move toward the target.
   always_comb begin
      state_nx_s  = state_r;
      target_nx_s = target_r;
      cur_nx_s    = cur_r;
      cnt_nx_s    = cnt_r;
      cnt_inc_s   = {1'b0, cnt_r} + {{RATE_W{1'b0}}, 1'b1};
      if (load) begin
         target_nx_s = load_duty;
         cnt_nx_s    = {RATE_W{1'b0}};
         state_nx_s  = (load_duty != cur_r) ? ST_RAMP : ST_IDLE;
      end else if (boundary && (state_r == ST_RAMP)) begin
         if (ramp_rate == {RATE_W{1'b0}}) begin
            cur_nx_s   = target_r;
            cnt_nx_s   = {RATE_W{1'b0}};
            state_nx_s = ST_IDLE;
         end else if (cnt_inc_s >= {1'b0, ramp_rate}) begin
            cnt_nx_s = {RATE_W{1'b0}};
            if (target_r > cur_r) begin
               cur_nx_s = cur_r + {{(RES_W-1){1'b0}}, 1'b1};
            end else begin
               cur_nx_s = cur_r - {{(RES_W-1){1'b0}}, 1'b1};
            end
            state_nx_s = (cur_nx_s == target_r) ? ST_IDLE : ST_RAMP;
         end else begin
            cnt_nx_s = cnt_inc_s[RATE_W-1:0];
         end
      end else begin
         state_nx_s = state_r;
      end
   end

   // Output decode: full scale is special-cased so the all-ones duty never drops at the last phase.
   always_comb begin
      pwm_nx_s = 1'b0;
      busy_s   = 1'b0;
      if (!ready) begin
         pwm_nx_s = 1'b0;
      end else if (cur_r == DUTY_FULL) begin
         pwm_nx_s = 1'b1;
      end else if (cur_r == DUTY_ZERO) begin
         pwm_nx_s = 1'b0;
      end else begin
         pwm_nx_s = (phase < cur_r);
      end
      case (state_r)
         ST_IDLE: busy_s = 1'b0;
         ST_RAMP: busy_s = 1'b1;
         default: busy_s = 1'b0;
      endcase
   end

   assign pwm_out   = pwm_r;
   assign cur_duty  = cur_r;
   assign ramp_busy = busy_s;

endmodule

// File: rtl/tft_pwm_dimmer.sv
// Multi-channel backlight PWM: power-up delay, shared prescaler/phase timebase, per-channel ramps.
module tft_pwm_dimmer
   import tft_pwm_pkg::*;
#(
   parameter int CH          = DEF_CH,
   parameter int RES_W       = DEF_RES_W,
   parameter int PRESC_W     = DEF_PRESC_W,
   parameter int PRESC_DIV   = DEF_PRESC_DIV,
   parameter int STARTUP_CNT = DEF_STARTUP_CNT,
   parameter int RATE_W      = DEF_RATE_W
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic [CH*RES_W-1:0] target_duty,
   input  logic [CH-1:0]       target_load,
   input  logic [RATE_W-1:0]   ramp_rate,
   output logic [CH-1:0]       pwm_out,
   output logic [CH*RES_W-1:0] cur_duty,
   output logic [CH-1:0]       ramp_busy,
   output logic                ready,
   output logic                period_tick
);

   localparam int                SU_W       = $clog2(STARTUP_CNT + 1);
   localparam logic [SU_W-1:0]   SU_LAST    = SU_W'(STARTUP_CNT - 1);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
   localparam logic [RES_W-1:0]  PHASE_LAST = {RES_W{1'b1}};

   logic [SU_W-1:0]    su_cnt_r;
   logic               ready_r;
   logic [PRESC_W-1:0] presc_cnt_r;
   logic [RES_W-1:0]   phase_r;
   logic               period_tick_r;
   logic               presc_tick_s;
   logic               boundary_s;

   assign presc_tick_s = ready_r && (presc_cnt_r == PRESC_LAST);
   assign boundary_s   = presc_tick_s && (phase_r == PHASE_LAST);

   // Power-up delay; the counter freezes once ready is set.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         su_cnt_r <= {SU_W{1'b0}};
         ready_r  <= 1'b0;
      end else if (!ready_r) begin
         su_cnt_r <= su_cnt_r + SU_W'(1);
         ready_r  <= (su_cnt_r == SU_LAST);
      end else begin
         su_cnt_r <= su_cnt_r;
         ready_r  <= 1'b1;
      end
   end

   // Prescaler and phase timebase, held at zero until ready.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         presc_cnt_r   <= {PRESC_W{1'b0}};
         phase_r       <= {RES_W{1'b0}};
         period_tick_r <= 1'b0;
      end else if (!ready_r) begin
         presc_cnt_r   <= {PRESC_W{1'b0}};
         phase_r       <= {RES_W{1'b0}};
         period_tick_r <= 1'b0;
      end else begin
         presc_cnt_r   <= presc_tick_s ? {PRESC_W{1'b0}} : presc_cnt_r + PRESC_W'(1);
         phase_r       <= presc_tick_s ? phase_r + RES_W'(1) : phase_r;
         period_tick_r <= boundary_s;
      end
   end

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      tft_pwm_channel #(
         .RES_W  (RES_W),
         .RATE_W (RATE_W)
      ) u_ch (
         .clk       (clk),
         .nrst      (nrst),
         .ready     (ready_r),
         .boundary  (boundary_s),
         .phase     (phase_r),
         .load      (target_load[gi]),
         .load_duty (target_duty[duty_lo(gi, RES_W) +: RES_W]),
         .ramp_rate (ramp_rate),
         .pwm_out   (pwm_out[gi]),
         .cur_duty  (cur_duty[duty_lo(gi, RES_W) +: RES_W]),
         .ramp_busy (ramp_busy[gi])
      );
   end

   assign ready       = ready_r;
   assign period_tick = period_tick_r;

endmodule
